pipe_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage (IF/ID/EX/MEM/WB) pipelined successor of the single-cycle RV32I core.
- Keeps its own shadow pipeline of destination-register tags for the EX, MEM and WB stages.
- From these tags it generates PC/IF-ID enables, flush/bubble controls and EX-stage operand forwarding selects.
- Sits beside the datapath; drives only enables and mux selects, never data.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipe_hazard_ctrl_fwd_select.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the 5-stage pipeline hazard/forwarding controller.
//   TAG_AW       : register address width carried in the stage tags
//   REG_ZERO     : architectural x0 (never a real producer)
//   stage_tag_t  : per-stage shadow tag {valid, rd, reg_write, is_load, rs1, rs2}
//   fwd_sel_t    : EX operand mux select encoding
//   produces()   : true when a stage tag will write the given source register
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int TAG_AW = 5;

  localparam logic [TAG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
    logic [TAG_AW-1:0] rs1;
    logic [TAG_AW-1:0] rs2;
  } stage_tag_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // A stage is a forwarding source for rs only if it really writes a
  // non-zero destination equal to rs; x0 reads must always see the RF zero.
  function automatic logic produces(input stage_tag_t t, input logic [TAG_AW-1:0] rs);
    return t.valid && t.reg_write && (t.rd != REG_ZERO) && (t.rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Combinational forwarding comparator for one EX operand.
// Ports:
//   ex_rs   : source register of the instruction currently in EX
//   mem_tag : shadow tag of the MEM stage
//   wb_tag  : shadow tag of the WB stage
//   sel     : FWD_MEM if MEM produces ex_rs, else FWD_WB if WB does, else FWD_RF
// -----------------------------------------------------------------------------
module fwd_select
  import pipe_pkg::*;
(
  input  logic [TAG_AW-1:0] ex_rs,
  input  stage_tag_t        mem_tag,
  input  stage_tag_t        wb_tag,
  output fwd_sel_t          sel
);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    sel = FWD_RF;
    if (produces(mem_tag, ex_rs)) begin
      sel = FWD_MEM;
    end else if (produces(wb_tag, ex_rs)) begin
      sel = FWD_WB;
    end
  end

  // Load flag and source fields of the producer tags play no part in forwarding.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{mem_tag.is_load, mem_tag.rs1, mem_tag.rs2,
                             wb_tag.is_load, wb_tag.rs1, wb_tag.rs2};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and forwarding controller for the 5-stage (IF/ID/EX/MEM/WB) RV32I
// pipeline. Keeps a shadow pipeline of destination tags for EX, MEM and WB and
// derives fetch enables, bubble/flush controls and EX forwarding selects.
// Drives only enables and mux selects, never data.
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   imem_ready          : instruction memory has data for the current PC
//   id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load : ID instruction
//   ex_branch_taken     : branch/jump in EX resolved taken
//   pc_en, ifid_en      : PC / IF-ID register load enables
//   ifid_flush          : load a bubble into IF/ID
//   idex_flush          : load a bubble into ID/EX
//   fwd_a, fwd_b        : EX operand selects (00 RF, 01 WB, 10 MEM ALU)
//   stall_cnt, flush_cnt: performance counters
//
// Build option: define PIPE_HAZARD_PERF_EN to build saturating stall/flush
// counters; otherwise the counter ports are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_tag_t ex_tag_reg, mem_tag_reg, wb_tag_reg;
  stage_tag_t id_tag, ex_tag_next;
  logic       lu;

  always_comb begin
    id_tag           = '0;
    id_tag.valid     = id_valid;
    id_tag.rd        = id_rd;
    id_tag.reg_write = id_reg_write;
    id_tag.is_load   = id_is_load;
    id_tag.rs1       = id_rs1;
    id_tag.rs2       = id_rs2;
  end

  // Load in EX whose result an ID source needs: data not available in time
  // even via MEM forwarding, so ID must wait one cycle.
  assign lu = id_valid && ex_tag_reg.valid && ex_tag_reg.is_load &&
              (ex_tag_reg.rd != REG_ZERO) &&
              ((ex_tag_reg.rd == id_rs1) || (ex_tag_reg.rd == id_rs2));

  // Pipeline control, highest priority first: reset, taken branch, load-use,
  // fetch stall, normal flow.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Both younger instructions are on the wrong path.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      // Hold PC and ID, send one bubble into EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      // No fetch data: bubble into ID, older stages keep moving.
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    ex_tag_next = '0;
    if (!idex_flush && id_valid) begin
      ex_tag_next = id_tag;
    end
  end

  // Downstream tags never stall; only the entry into EX is gated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_tag_reg  <= '0;
      mem_tag_reg <= '0;
      wb_tag_reg  <= '0;
    end else begin
      ex_tag_reg  <= ex_tag_next;
      mem_tag_reg <= ex_tag_reg;
      wb_tag_reg  <= mem_tag_reg;
    end
  end

  // One comparator per EX operand: index 0 -> rs1 (fwd_a), 1 -> rs2 (fwd_b).
  logic [TAG_AW-1:0] ex_rs   [2];
  fwd_sel_t          sel_raw [2];

  assign ex_rs[0] = ex_tag_reg.rs1;
  assign ex_rs[1] = ex_tag_reg.rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_select u_fwd_select (
        .ex_rs   (ex_rs[gi]),
        .mem_tag (mem_tag_reg),
        .wb_tag  (wb_tag_reg),
        .sel     (sel_raw[gi])
      );
    end
  endgenerate

  // A bubble in EX consumes nothing; reset forces the register-file path
  // even before the tags have been cleared.
  assign fwd_a = (rst && ex_tag_reg.valid) ? sel_raw[0] : FWD_RF;
  assign fwd_b = (rst && ex_tag_reg.valid) ? sel_raw[1] : FWD_RF;

`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // A load-use cycle overridden by a taken branch is a flush, not a stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (lu && !ex_branch_taken && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
      if (ex_branch_taken && (flush_cnt_reg != CNT_MAX)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Scoreboard bench: each cycle the stimulus drives the ID/control inputs and
// pushes the hand-derived expected controls and forward selects; at the
// falling edge the entry is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, ifid_en, ifid_flush, idex_flush}
  localparam logic [3:0] C_N   = 4'b1100;
  localparam logic [3:0] C_LU  = 4'b0001;
  localparam logic [3:0] C_BR  = 4'b1111;
  localparam logic [3:0] C_FS  = 4'b0110;
  localparam logic [3:0] C_RST = 4'b0011;

  logic              clk;
  logic              rst;
  logic              imem_ready;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_is_load;
  logic              ex_branch_taken;
  logic              pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_ready      (imem_ready),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pipeline cycle: drive at posedge+1, score at negedge, return at next posedge+1.
  task automatic run_cycle(input string tag, input logic r, input logic im, input logic br,
                           input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic ld,
                           input logic [3:0] exp_ctrl, input logic [1:0] exp_fa,
                           input logic [1:0] exp_fb);
    logic [7:0] e;
    string      t;
    rst             = r;
    imem_ready      = im;
    ex_branch_taken = br;
    id_valid        = vld;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_rd           = rd;
    id_reg_write    = rw;
    id_is_load      = ld;
    exp_q.push_back({exp_ctrl, exp_fa, exp_fb});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".ctrl"}, {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, e[7:4]});
    check_eq({t, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e[3:2]});
    check_eq({t, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e[1:0]});
    $display("[TB] %-4s ctrl=%b%b%b%b fwd_a=%b fwd_b=%b stall=%0d flush=%0d",
             t, pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, stall_cnt, flush_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int exp_stall, input int exp_flush);
    check_eq({tag, ".stall_cnt"}, stall_cnt, PERF ? exp_stall : 0);
    check_eq({tag, ".flush_cnt"}, flush_cnt, PERF ? exp_flush : 0);
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; id_valid = 1'b0; ex_branch_taken = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with busy inputs (branch, would-be load-use)
    run_cycle("R0", 0, 1, 1, 1, 5'd7, 5'd7, 5'd7, 1, 1, C_RST, 2'b00, 2'b00);
    run_cycle("R1", 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 1, 1, C_RST, 2'b00, 2'b00);
    run_cycle("R2", 0, 1, 0, 1, 5'd3, 5'd4, 5'd7, 1, 1, C_RST, 2'b00, 2'b00);
    check_cnt("RST", 0, 0);
    run_cycle("REL", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b00, 2'b00);

    // MEM forward: add x5 then sub rs1=x5
    run_cycle("A1", 1, 1, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("A2", 1, 1, 0, 1, 5'd5, 5'd6, 5'd8, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("A3", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b10, 2'b00);
    run_cycle("A4", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b00, 2'b00);

    // WB forward: one independent instruction in between
    run_cycle("B1", 1, 1, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("B2", 1, 1, 0, 1, 5'd3, 5'd4, 5'd9, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("B3", 1, 1, 0, 1, 5'd5, 5'd6, 5'd8, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("B4", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b01, 2'b00);

    // MEM and WB both write x5: youngest (MEM) wins on both operands
    run_cycle("P1", 1, 1, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("P2", 1, 1, 0, 1, 5'd1, 5'd2, 5'd5, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("P3", 1, 1, 0, 1, 5'd5, 5'd5, 5'd8, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("P4", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b10, 2'b10);

    // Load-use: lw x7 then add rs2=x7 -> one stall, then WB forward
    run_cycle("C1", 1, 1, 0, 1, 5'd3, 5'd0, 5'd7, 1, 1, C_N, 2'b00, 2'b00);
    run_cycle("C2", 1, 1, 0, 1, 5'd4, 5'd7, 5'd10, 1, 0, C_LU, 2'b00, 2'b00);
    check_cnt("C2", 1, 0);
    run_cycle("C3", 1, 1, 0, 1, 5'd4, 5'd7, 5'd10, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("C4", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b00, 2'b01);
    check_cnt("C4", 1, 0);

    // x0: load to x0 then reader of x0 -> no stall, no forward
    run_cycle("D1", 1, 1, 0, 1, 5'd3, 5'd4, 5'd0, 1, 1, C_N, 2'b00, 2'b00);
    run_cycle("D2", 1, 1, 0, 1, 5'd0, 5'd0, 5'd11, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("D3", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b00, 2'b00);

    // Branch taken in the same cycle as a load-use hazard
    run_cycle("E1", 1, 1, 0, 1, 5'd3, 5'd4, 5'd7, 1, 1, C_N, 2'b00, 2'b00);
    run_cycle("E2", 1, 1, 1, 1, 5'd7, 5'd4, 5'd12, 1, 0, C_BR, 2'b00, 2'b00);
    check_cnt("E2", 1, 1);
    run_cycle("E3", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b00, 2'b00);

    // Fetch stall for 2 cycles with a load in MEM, dependent reaches EX
    run_cycle("F1", 1, 1, 0, 1, 5'd3, 5'd4, 5'd7, 1, 1, C_N, 2'b00, 2'b00);
    run_cycle("F2", 1, 1, 0, 1, 5'd3, 5'd4, 5'd9, 1, 0, C_N, 2'b00, 2'b00);
    run_cycle("F3", 1, 0, 0, 1, 5'd7, 5'd4, 5'd12, 1, 0, C_FS, 2'b00, 2'b00);
    run_cycle("F4", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_FS, 2'b01, 2'b00);
    run_cycle("F5", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_N, 2'b00, 2'b00);
    check_cnt("F5", 1, 1);

    // Reset arriving during a load-use hazard: no stall survives it
    run_cycle("M1", 1, 1, 0, 1, 5'd3, 5'd4, 5'd7, 1, 1, C_N, 2'b00, 2'b00);
    run_cycle("M2", 0, 1, 0, 1, 5'd4, 5'd7, 5'd10, 1, 0, C_RST, 2'b00, 2'b00);
    check_cnt("M2", 0, 0);
    run_cycle("M3", 1, 1, 0, 1, 5'd4, 5'd7, 5'd10, 1, 0, C_N, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
